// File: rtl/test_monitor.sv
// test_monitor: watches a CPU under test and checks its WWD output against
// an expectation table of (num_inst, answer) pairs.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   num_inst            retired-instruction count from the cpu
//   output_port         cpu WWD output value
//   is_halted           cpu halted flag
//   start               one-cycle pulse; begins a run from IDLE
//   tbl_we/idx/num/ans  expectation-table write port (IDLE only)
//   done                run finished, results frozen
//   finish_cause        00 none, 01 fail, 10 halt, 11 timeout
//   pass_count          entries passed so far
//   all_pass            done and every entry passed
//   fail_idx/fail_value index and output_port of the first failing entry
//   num_clock           run cycles elapsed
module test_monitor #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 56,
  parameter int MAX_CYCLES = 10000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  input  logic                 start,
  input  logic                 tbl_we,
  input  logic [5:0]           tbl_idx,
  input  logic [WORD_SIZE-1:0] tbl_num,
  input  logic [WORD_SIZE-1:0] tbl_ans,
  output logic                 done,
  output logic [1:0]           finish_cause,
  output logic [6:0]           pass_count,
  output logic                 all_pass,
  output logic [5:0]           fail_idx,
  output logic [WORD_SIZE-1:0] fail_value,
  output logic [WORD_SIZE-1:0] num_clock
);

  localparam logic [6:0]           NUM_TEST_W = 7'(NUM_TEST);
  localparam logic [WORD_SIZE-1:0] TIMEOUT_AT = WORD_SIZE'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [6:0]           ptr;
  logic [WORD_SIZE-1:0] tbl_num_mem [NUM_TEST];
  logic [WORD_SIZE-1:0] tbl_ans_mem [NUM_TEST];

  logic                 ptr_valid;
  logic [WORD_SIZE-1:0] cur_num;
  logic [WORD_SIZE-1:0] cur_ans;
  logic                 hit, pass_ev, fail_ev, skip_ev, halt_ev, timeout_ev;

  // Table is deliberately not reset so a run can be repeated after reset.
  always_ff @(posedge clk) begin
    if (reset_n && tbl_we && (state == IDLE) && ({1'b0, tbl_idx} < NUM_TEST_W)) begin
      tbl_num_mem[tbl_idx] <= tbl_num;
      tbl_ans_mem[tbl_idx] <= tbl_ans;
    end
  end

  always_comb begin
    ptr_valid = (ptr < NUM_TEST_W);
    cur_num   = '0;
    cur_ans   = '0;
    if (ptr_valid) begin
      cur_num = tbl_num_mem[ptr[5:0]];
      cur_ans = tbl_ans_mem[ptr[5:0]];
    end
    hit        = ptr_valid && (num_inst == cur_num);
    pass_ev    = hit && (output_port == cur_ans);
    fail_ev    = hit && (output_port != cur_ans);
    // Entries are sorted by num_inst, so an overtaken entry can never match.
    skip_ev    = ptr_valid && (num_inst > cur_num);
    halt_ev    = is_halted;
    timeout_ev = (num_clock == TIMEOUT_AT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      done         <= 1'b0;
      finish_cause <= 2'b00;
      pass_count   <= '0;
      fail_idx     <= '0;
      fail_value   <= '0;
      num_clock    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            ptr        <= '0;
            pass_count <= '0;
            num_clock  <= '0;
          end
        end
        RUN: begin
          if (pass_ev) begin
            pass_count <= pass_count + 7'd1;
            ptr        <= ptr + 7'd1;
          end else if (skip_ev) begin
            ptr <= ptr + 7'd1;
          end
          // The finishing cycle does not advance num_clock, so a timeout
          // leaves it at MAX_CYCLES-1.
          if (fail_ev) begin
            state        <= DONE;
            done         <= 1'b1;
            finish_cause <= 2'b01;
            fail_idx     <= ptr[5:0];
            fail_value   <= output_port;
          end else if (halt_ev) begin
            state        <= DONE;
            done         <= 1'b1;
            finish_cause <= 2'b10;
          end else if (timeout_ev) begin
            state        <= DONE;
            done         <= 1'b1;
            finish_cause <= 2'b11;
          end else begin
            num_clock <= num_clock + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign all_pass = done & (pass_count == NUM_TEST_W);

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: table-driven per-cycle vectors for the
// basic pass/halt and skip flows, plus hand-written fail, reset, timeout
// and full-table sequences.
module tb_test_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] num_inst, output_port;
  logic        is_halted, start, tbl_we;
  logic [5:0]  tbl_idx;
  logic [15:0] tbl_num, tbl_ans;
  logic        done;
  logic [1:0]  finish_cause;
  logic [6:0]  pass_count;
  logic        all_pass;
  logic [5:0]  fail_idx;
  logic [15:0] fail_value;
  logic [15:0] num_clock;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  test_monitor #(.WORD_SIZE(16), .NUM_TEST(56), .MAX_CYCLES(10000)) dut (
    .clk(clk), .reset_n(reset_n), .num_inst(num_inst), .output_port(output_port),
    .is_halted(is_halted), .start(start), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_num(tbl_num), .tbl_ans(tbl_ans), .done(done), .finish_cause(finish_cause),
    .pass_count(pass_count), .all_pass(all_pass), .fail_idx(fail_idx),
    .fail_value(fail_value), .num_clock(num_clock)
  );

  typedef struct {
    logic [15:0] ni;
    logic [15:0] op;
    logic        h;
    logic [6:0]  pc;
    logic        d;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic load(input int idx, input logic [15:0] n, input logic [15:0] a);
    tbl_we  = 1'b1;
    tbl_idx = 6'(idx);
    tbl_num = n;
    tbl_ans = a;
    step();
    tbl_we  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input logic [15:0] ni, input logic [15:0] op, input logic h);
    num_inst    = ni;
    output_port = op;
    is_halted   = h;
    step();
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(vecs[i].ni, vecs[i].op, vecs[i].h);
      chk($sformatf("vec%0d pass_count", i), 32'(pass_count), 32'(vecs[i].pc));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].d));
      chk($sformatf("vec%0d cause", i), 32'(finish_cause), 32'(vecs[i].cause));
    end
  endtask

  initial begin
    // Basic run: entries (3,0),(5,0),(11,1), halt at 12
    vecs[0]  = '{16'd1,  16'd0, 1'b0, 7'd0, 1'b0, 2'b00};
    vecs[1]  = '{16'd3,  16'd0, 1'b0, 7'd1, 1'b0, 2'b00};
    vecs[2]  = '{16'd4,  16'd7, 1'b0, 7'd1, 1'b0, 2'b00};
    vecs[3]  = '{16'd5,  16'd0, 1'b0, 7'd2, 1'b0, 2'b00};
    vecs[4]  = '{16'd8,  16'd3, 1'b0, 7'd2, 1'b0, 2'b00};
    vecs[5]  = '{16'd11, 16'd1, 1'b0, 7'd3, 1'b0, 2'b00};
    vecs[6]  = '{16'd12, 16'd5, 1'b1, 7'd3, 1'b1, 2'b10};
    vecs[7]  = '{16'd13, 16'd0, 1'b0, 7'd3, 1'b1, 2'b10};
    // Skip run: num_inst jumps 4 -> 6 past entry (5,0)
    vecs[8]  = '{16'd3,  16'd0, 1'b0, 7'd1, 1'b0, 2'b00};
    vecs[9]  = '{16'd4,  16'd0, 1'b0, 7'd1, 1'b0, 2'b00};
    vecs[10] = '{16'd6,  16'd9, 1'b0, 7'd1, 1'b0, 2'b00};
    vecs[11] = '{16'd11, 16'd1, 1'b0, 7'd2, 1'b0, 2'b00};
    vecs[12] = '{16'd12, 16'd0, 1'b1, 7'd2, 1'b1, 2'b10};
    vecs[13] = '{16'd13, 16'd0, 1'b0, 7'd2, 1'b1, 2'b10};

    reset_n = 1'b1; start = 1'b0; tbl_we = 1'b0; tbl_idx = '0;
    tbl_num = '0; tbl_ans = '0; num_inst = '0; output_port = '0; is_halted = 1'b0;
    do_reset();
    chk("reset done", 32'(done), 0);
    chk("reset cause", 32'(finish_cause), 0);
    chk("reset pass_count", 32'(pass_count), 0);
    chk("reset num_clock", 32'(num_clock), 0);
    chk("reset all_pass", 32'(all_pass), 0);

    load(0, 16'd3, 16'd0);
    load(1, 16'd5, 16'd0);
    load(2, 16'd11, 16'd1);
    load(3, 16'hFFFF, 16'd0);
    pulse_start();
    run_vecs(0, 7);
    chk("basic num_clock", 32'(num_clock), 6);
    chk("basic all_pass", 32'(all_pass), 0);
    pulse_start();
    chk("start in DONE done", 32'(done), 1);
    chk("start in DONE num_clock", 32'(num_clock), 6);

    do_reset();
    pulse_start();
    run_vecs(8, 13);

    // Table write in RUN ignored, then reset mid-run
    do_reset();
    pulse_start();
    drive(16'd3, 16'd0, 1'b0);
    tbl_we = 1'b1; tbl_idx = 6'd1; tbl_num = 16'd4; tbl_ans = 16'd0;
    drive(16'd2, 16'd0, 1'b0);
    tbl_we = 1'b0;
    drive(16'd4, 16'd5, 1'b0);
    chk("run write ignored done", 32'(done), 0);
    chk("run write ignored pass_count", 32'(pass_count), 1);
    reset_n = 1'b0;
    step();
    chk("midrun reset done", 32'(done), 0);
    chk("midrun reset cause", 32'(finish_cause), 0);
    chk("midrun reset pass_count", 32'(pass_count), 0);
    chk("midrun reset num_clock", 32'(num_clock), 0);
    chk("midrun reset fail_idx", 32'(fail_idx), 0);
    chk("midrun reset fail_value", 32'(fail_value), 0);

    // Reset overrides start and tbl_we
    start = 1'b1; tbl_we = 1'b1; tbl_idx = 6'd0; tbl_num = 16'd3; tbl_ans = 16'd5;
    step();
    start = 1'b0; tbl_we = 1'b0; reset_n = 1'b1;
    drive(16'd3, 16'd0, 1'b0);
    chk("reset beats start pass_count", 32'(pass_count), 0);
    chk("reset beats start num_clock", 32'(num_clock), 0);
    pulse_start();
    drive(16'd3, 16'd0, 1'b0);
    chk("rerun entry0 pass_count", 32'(pass_count), 1);
    drive(16'd5, 16'd0, 1'b0);
    chk("rerun entry1 pass_count", 32'(pass_count), 2);
    chk("rerun entry1 done", 32'(done), 0);

    // Mismatch -> fail
    do_reset();
    load(0, 16'd13, 16'hFFFE);
    load(1, 16'hFFFF, 16'd0);
    pulse_start();
    drive(16'd12, 16'd2, 1'b0);
    chk("pre-fail done", 32'(done), 0);
    drive(16'd13, 16'd2, 1'b0);
    chk("fail done", 32'(done), 1);
    chk("fail cause", 32'(finish_cause), 1);
    chk("fail idx", 32'(fail_idx), 0);
    chk("fail value", 32'(fail_value), 32'h0002);
    chk("fail pass_count", 32'(pass_count), 0);
    chk("fail num_clock", 32'(num_clock), 1);

    // Mismatch and halt together: fail wins
    do_reset();
    pulse_start();
    drive(16'd13, 16'd2, 1'b1);
    chk("fail+halt cause", 32'(finish_cause), 1);
    chk("fail+halt done", 32'(done), 1);

    // Timeout
    do_reset();
    pulse_start();
    num_inst = 16'd0; output_port = 16'd0; is_halted = 1'b0;
    repeat (9999) step();
    chk("pre-timeout done", 32'(done), 0);
    chk("pre-timeout num_clock", 32'(num_clock), 9999);
    step();
    chk("timeout done", 32'(done), 1);
    chk("timeout cause", 32'(finish_cause), 3);
    chk("timeout num_clock", 32'(num_clock), 9999);
    repeat (3) step();
    chk("timeout frozen num_clock", 32'(num_clock), 9999);

    // Full table passes
    do_reset();
    for (int i = 0; i < 56; i++) load(i, 16'(i + 1), 16'(i) ^ 16'hA5A5);
    pulse_start();
    for (int i = 0; i < 56; i++) drive(16'(i + 1), 16'(i) ^ 16'hA5A5, 1'b0);
    chk("full pass_count", 32'(pass_count), 56);
    chk("full all_pass before done", 32'(all_pass), 0);
    drive(16'd100, 16'd7, 1'b0);
    drive(16'd101, 16'd8, 1'b0);
    chk("past end done", 32'(done), 0);
    drive(16'd102, 16'd0, 1'b1);
    chk("full done", 32'(done), 1);
    chk("full cause", 32'(finish_cause), 2);
    chk("full pass_count final", 32'(pass_count), 56);
    chk("full all_pass", 32'(all_pass), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
